// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pins, frames 11-bit packets and decodes
// scan codes into make strobes with E0-extension flag, dropping breaks and optional repeats.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter bit REPEAT_FILTER  = 1'b1
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_ext,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          fall, ps2_bit;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          start_en, shift_en, par_en, stop_fall, byte_ok, err;
    logic          ext_pend, brk_pend;
    logic          held_vld, held_ext;
    logic [7:0]    held_code;
    logic          held_match;

    // clk_prev is the edge-history flop behind the 2-flop synchronizer
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign ps2_bit = data_sync[1];

    // A fall on the expiry cycle wins over the timeout
    assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (fall) begin
            case (state)
                IDLE:    if (!ps2_bit) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        start_en  = fall && (state == IDLE) && !ps2_bit;
        shift_en  = fall && (state == DATA);
        par_en    = fall && (state == PARITY);
        stop_fall = fall && (state == STOP);
        byte_ok   = stop_fall && ps2_bit && (^{shreg, par_bit});
        err       = (stop_fall && !byte_ok) || tmo_hit;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
        end else begin
            if (start_en) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {ps2_bit, shreg[7:1]};
            if (par_en) par_bit <= ps2_bit;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)                              tmo_cnt <= '0;
        else if (fall || state == IDLE || tmo_hit) tmo_cnt <= '0;
        else                                      tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign held_match = held_vld && (held_code == shreg) && (held_ext == ext_pend);

    // Scan-code decode: prefixes arm pending flags, breaks release the held key
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_in    <= 8'h00;
            key_en    <= 1'b0;
            key_ext   <= 1'b0;
            frame_err <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            held_vld  <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= 8'h00;
        end else begin
            key_en    <= 1'b0;
            frame_err <= err;
            if (err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (brk_pend) begin
                        if (held_match) held_vld <= 1'b0;
                    end else if (!(REPEAT_FILTER && held_match)) begin
                        key_in    <= shreg;
                        key_ext   <= ext_pend;
                        key_en    <= 1'b1;
                        held_vld  <= 1'b1;
                        held_code <= shreg;
                        held_ext  <= ext_pend;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames into a filtering and a
// non-filtering instance, strobes tallied on the falling system-clock edge.
module tb_ps2_key_decoder;
    localparam int TMO  = 100;
    localparam int HALF = 8;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_in,  nf_key_in;
    logic       key_en,  nf_key_en;
    logic       key_ext, nf_key_ext;
    logic       frame_err, nf_frame_err;

    int n_vec = 0, n_bad = 0;
    int cyc = 0, fall_cyc = 0, en_cyc = 0;
    int en_cnt = 0, err_cnt = 0, nf_cnt = 0, dbl_en = 0, dbl_err = 0;
    logic prev_en = 1'b0, prev_err = 1'b0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .REPEAT_FILTER(1'b1)) dut (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_in(key_in), .key_en(key_en), .key_ext(key_ext), .frame_err(frame_err));

    ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .REPEAT_FILTER(1'b0)) dut_nf (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_in(nf_key_in), .key_en(nf_key_en), .key_ext(nf_key_ext), .frame_err(nf_frame_err));

    always #5 iVGA_CLK = ~iVGA_CLK;
    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    always @(negedge iVGA_CLK) begin
        if (key_en) begin
            en_cnt++;
            en_cyc = cyc;
            if (prev_en) dbl_en++;
        end
        if (frame_err) begin
            err_cnt++;
            if (prev_err) dbl_err++;
        end
        if (nf_key_en) nf_cnt++;
        prev_en  = key_en;
        prev_err = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iVGA_CLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        tick(HALF);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(stop);
        tick(6);
    endtask

    initial begin
        int e0, x0, n0;
        bit got;

        tick(3);
        check("rst_key_in", key_in, 8'h00);
        check("rst_key_en", key_en, 1'b0);
        check("rst_key_ext", key_ext, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        iRST_n = 1'b1;
        tick(5);

        e0 = en_cnt; x0 = err_cnt;
        send_frame(8'h6B, 1'b0, 1'b1);
        check("6B_key_in", key_in, 8'h6B);
        check("6B_key_ext", key_ext, 1'b0);
        check("6B_strobes", en_cnt - e0, 1);
        check("6B_no_err", err_cnt - x0, 0);
        check("6B_latency", en_cyc - fall_cyc, 3);

        e0 = en_cnt;
        send_frame(8'hE0, 1'b0, 1'b1);
        check("E0_no_strobe", en_cnt - e0, 0);
        send_frame(8'h74, 1'b0, 1'b1);
        check("E074_strobes", en_cnt - e0, 1);
        check("E074_key_in", key_in, 8'h74);
        check("E074_key_ext", key_ext, 1'b1);

        e0 = en_cnt; n0 = nf_cnt;
        repeat (3) send_frame(8'h6B, 1'b0, 1'b1);
        check("repeat_filtered", en_cnt - e0, 1);
        check("repeat_unfiltered", nf_cnt - n0, 3);
        e0 = en_cnt;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h6B, 1'b0, 1'b1);
        check("break_no_strobe", en_cnt - e0, 0);
        send_frame(8'h6B, 1'b0, 1'b1);
        check("remake_strobe", en_cnt - e0, 1);
        check("remake_key_in", key_in, 8'h6B);

        e0 = en_cnt; x0 = err_cnt;
        send_frame(8'h6B, 1'b1, 1'b1);
        check("badpar_err", err_cnt - x0, 1);
        check("badpar_no_strobe", en_cnt - e0, 0);
        check("badpar_key_in", key_in, 8'h6B);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check("post_err_key_in", key_in, 8'h74);
        check("post_err_key_ext", key_ext, 1'b1);

        x0 = err_cnt; e0 = en_cnt;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b0);
        check("badstop_err", err_cnt - x0, 1);
        send_frame(8'h74, 1'b0, 1'b1);
        check("err_clears_ext_strobe", en_cnt - e0, 1);
        check("err_clears_ext", key_ext, 1'b0);

        x0 = err_cnt; e0 = en_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        tick(TMO - 20);
        check("tmo_not_early", err_cnt - x0, 0);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick(1);
            if (err_cnt != x0) got = 1'b1;
        end
        check("tmo_err", err_cnt - x0, 1);
        tick(4);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("post_tmo_key_in", key_in, 8'h1C);
        check("post_tmo_strobe", en_cnt - e0, 1);

        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        iRST_n = 1'b0;
        tick(2);
        check("midrst_key_in", key_in, 8'h00);
        check("midrst_key_ext", key_ext, 1'b0);
        check("midrst_key_en", key_en, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        iRST_n = 1'b1;
        tick(5);
        e0 = en_cnt; x0 = err_cnt;
        send_frame(8'h72, 1'b0, 1'b1);
        check("post_rst_key_in", key_in, 8'h72);
        check("post_rst_strobe", en_cnt - e0, 1);
        check("post_rst_no_err", err_cnt - x0, 0);

        check("key_en_single_cycle", dbl_en, 0);
        check("frame_err_single_cycle", dbl_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 25000; idle cycles allowed between PS/2 clock falls inside a frame (1 ms at 25 MHz).
REQ-002 Parameter REPEAT_FILTER, default 1; when 1, typematic repeats of a held key are suppressed.
REQ-003 iVGA_CLK  input  1  system clock.
REQ-004 iRST_n  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  keyboard clock, asynchronous to iVGA_CLK.
REQ-006 ps2_data  input  1  keyboard data, asynchronous to iVGA_CLK.
REQ-007 key_in  output  8  last accepted make code; holds until the next accepted make.
REQ-008 key_en  output  1  one-cycle strobe marking a new key_in.
REQ-009 key_ext  output  1  key_in was preceded by the 0xE0 prefix; updates together with key_in.
REQ-010 frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-011 ps2_clk and ps2_data each pass through a 2-flop synchronizer; a falling edge is synchronized clk previous=1 and current=0, sampled once per iVGA_CLK.
REQ-012 Frame receiver FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on a detected fall, except timeout.
REQ-013 IDLE: fall with data=0 -> DATA, bit count 0; fall with data=1 -> stay IDLE, no error.
REQ-014 DATA: each fall shifts data in LSB first; after the 8th bit -> PARITY.
REQ-015 PARITY: a fall captures the parity bit -> STOP.
REQ-016 STOP: a fall with data=1 and odd parity over the 8 data bits plus parity -> byte valid; otherwise frame_err pulses; both cases -> IDLE.
REQ-017 Timeout counter clears on every fall and in IDLE; in any other state it increments per cycle; on reaching TIMEOUT_CYCLES -> IDLE, frame_err pulses, partial byte discarded.
REQ-018 Valid byte 0xE0 sets ext_pending; no strobe.
REQ-019 Valid byte 0xF0 sets brk_pending; no strobe.
REQ-020 Other valid byte with brk_pending=1 (break): clears the held-key record if code and ext match it; clears both pending flags; no strobe.
REQ-021 Other valid byte with brk_pending=0 (make): if REPEAT_FILTER=1 and code/ext equal the held-key record -> suppressed; otherwise key_in=code, key_ext=ext_pending, key_en=1, record updated; both pending flags cleared either way.
REQ-022 key_en asserts exactly in the cycle after the cycle in which the STOP-state fall is detected, for one cycle only; never asserted on two consecutive cycles.
REQ-023 Any frame_err clears ext_pending and brk_pending; the held-key record and key_in are unchanged.
REQ-024 With REPEAT_FILTER=0, every make byte produces a strobe.
REQ-025 Fall detected on the same cycle as timeout expiry: the fall wins; the counter clears and the FSM advances normally.

Reset
REQ-026 iRST_n low asynchronously forces: FSM IDLE, bit count 0, timeout counter 0, synchronizers 1, key_in=0x00, key_en=0, key_ext=0, frame_err=0, pending flags 0, held-key record invalid.
REQ-027 Reset asserted mid-frame discards the partial frame; the first complete frame after release decodes normally.

Verification
REQ-028 Frame 0x6B with correct parity -> key_in=0x6B, key_ext=0, key_en high exactly one cycle, frame_err stays 0.
REQ-029 Bytes E0, 74 -> a single strobe with key_in=0x74, key_ext=1; no strobe on E0.
REQ-030 REPEAT_FILTER=1: 6B, 6B, 6B -> one strobe; then F0, 6B, 6B -> no strobe on the break, one strobe on the final 6B.
REQ-031 Frame 0x6B with wrong parity -> frame_err one cycle, no key_en, key_in unchanged; following E0, 74 decodes with key_ext=1.
REQ-032 Start bit plus 4 data falls, then ps2_clk held high -> frame_err after TIMEOUT_CYCLES, FSM IDLE; next frame 0x1C -> key_in=0x1C.
REQ-033 iRST_n pulsed low after 5 falls of a frame -> all outputs reset values; following full frame 0x72 -> key_in=0x72, key_en pulse.
